// File: rtl/dsr_ctl.sv
// Decode-stage pipeline register for the Y86-64 pipeline, with its own stall/bubble
// generation from load/use, mispredicted-branch and ret conditions.
module dsr_ctl #(
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [3:0] SAOK      = 4'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  f_stat,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [3:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic        D_stall,
    output logic        D_bubble
);

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic loaduse;
    logic mispredict;
    logic ret_in_pipe;

    always_comb begin
        loaduse     = 1'b0;
        mispredict  = 1'b0;
        ret_in_pipe = 1'b0;
        // RNONE in E_dstM never matches, even when a decode source is also RNONE
        if ((E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != RNONE) &&
            (E_dstM == d_srcA || E_dstM == d_srcB))
            loaduse = 1'b1;
        if (E_icode == I_JXX && !e_Cnd)
            mispredict = 1'b1;
        if (D_icode == I_RET || E_icode == I_RET || M_icode == I_RET)
            ret_in_pipe = 1'b1;
    end

    // Stall wins over bubble: the load/use instruction must stay in decode.
    assign D_stall  = loaduse;
    assign D_bubble = !loaduse && (mispredict || ret_in_pipe);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_stat  <= SAOK;
            D_icode <= NOP_ICODE;
            D_ifun  <= 4'h0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= 64'h0;
            D_valP  <= 64'h0;
        end else if (D_stall) begin
            D_stat  <= D_stat;
            D_icode <= D_icode;
            D_ifun  <= D_ifun;
            D_rA    <= D_rA;
            D_rB    <= D_rB;
            D_valC  <= D_valC;
            D_valP  <= D_valP;
        end else if (D_bubble) begin
            D_stat  <= SAOK;
            D_icode <= NOP_ICODE;
            D_ifun  <= 4'h0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= 64'h0;
            D_valP  <= 64'h0;
        end else begin
            // Exception status codes pass through untouched; later stages handle them.
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end

endmodule

// File: doc/dsr_ctl.md
Name: dsr_ctl

Overview:
- Decode-stage pipeline register plus its hazard control for the Y86-64 five-stage pipeline.
- Sits directly downstream of the fetch stage and its F register.
- Captures fetch outputs (f_stat … f_valP) each clock and presents D_* fields to decode/register-file logic.
- Generates D_stall/D_bubble internally from load/use, mispredicted-branch and ret conditions.

Parameters:
- NOP_ICODE, 4'h1, icode injected on bubble/reset
- RNONE, 4'hF, register ID meaning "no register"
- SAOK, 4'h1, status code for normal operation (SADR=2, SINS=3, SHLT=4 pass through unchanged)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- f_stat  input  4  fetch status
- f_icode  input  4  fetch icode
- f_ifun  input  4  fetch ifun
- f_rA  input  4  fetch rA
- f_rB  input  4  fetch rB
- f_valC  input  64  fetch constant word
- f_valP  input  64  fetch incremented PC
- E_icode  input  4  icode in execute
- E_dstM  input  4  memory destination in execute
- e_Cnd  input  1  execute condition result
- M_icode  input  4  icode in memory stage
- d_srcA  input  4  decode source A (combinational from D_*)
- d_srcB  input  4  decode source B
- D_stat, D_icode, D_ifun, D_rA, D_rB  output  4 each  registered decode fields
- D_valC, D_valP  output  64 each  registered words
- D_stall  output  1  combinational stall indication
- D_bubble  output  1  combinational bubble indication

Behaviour:
- loaduse = (E_icode==4'h5 | E_icode==4'hB) & (E_dstM!=RNONE) & (E_dstM==d_srcA | E_dstM==d_srcB).
- mispredict = (E_icode==4'h7) & !e_Cnd.
- ret_in_pipe = D_icode==4'h9 | E_icode==4'h9 | M_icode==4'h9.
- D_stall = loaduse.
- D_bubble = mispredict | (ret_in_pipe & !loaduse).
- Stall has priority: if D_stall=1, D_bubble forced 0.
- Both outputs are purely combinational, with no latency.
- Register update on posedge clk, in priority order:
  - D_stall: all D_* hold.
  - D_bubble: load the nop bundle: stat=SAOK, icode=NOP_ICODE, ifun=0, rA=rB=RNONE, valC=0, valP=0.
  - Otherwise: capture all f_* fields.
- Reset (async, immediate on reset rising, independent of clk): D_* take the nop bundle above.
- Reset mid-stall or mid-bubble overrides both; the first capture happens on the first posedge after reset deasserts, with normal stall/bubble evaluation.
- Non-AOK f_stat (SADR/SINS/SHLT) is latched unmodified; this block does no exception suppression.
- D_stall/D_bubble remain valid during reset but have no effect on D_*.
- Width rules: all fields unsigned bit copies, no sign extension or truncation; valC/valP 64-bit transparent.
- E_dstM==RNONE never triggers loaduse, even if d_srcA/d_srcB==RNONE.
- Combinational loop caution: d_srcA/d_srcB derive from D_* registers, not f_*, so there is no loop.

Test Plan:
- Reset: assert reset asynchronously between edges with f_icode=6 -> D_icode=1, D_rA=D_rB=F, D_stat=1, D_valC=0 immediately; deassert, next edge -> D_icode=6.
- Normal flow: f_icode=3, f_rB=2, f_valC=64'h100, f_valP=64'h20A, no hazards -> next edge D_* equal inputs; D_stall=D_bubble=0.
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> D_stall=1, D_bubble=0, D_* unchanged for that edge. Same setup with E_dstM=F -> no stall.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, next edge nop bundle. With e_Cnd=1 -> normal capture.
- Ret: D_icode=9, then E_icode=9, then M_icode=9 on three successive cycles -> D_bubble=1 on each; D holds nop for three edges, then captures return-target instruction.
- Load/use + ret concurrent: E_icode=B, E_dstM=4, d_srcB=4, D_icode=9 -> D_stall=1, D_bubble=0, D_icode stays 9.
